arith_unit_seq: RTL and testbench

Parametrised, multi-cycle successor to the team's 32-bit combinational add/sub unit. It computes a±b over WIDTH bits, CHUNK bits per cycle, through a ripple carry register. It supports signed and unsigned modes, reports overflow, and can optionally saturate the result. Operands enter and results leave through valid/ready handshakes, so the block drops into pipelined datapaths without a WIDTH-bit carry chain.

---
 rtl/arith_unit_seq.sv | 113 +++++++++++
 tb/tb_arith_unit_seq.sv | 133 +++++++++++++
 2 files changed

// File: rtl/arith_unit_seq.sv
// arith_unit_seq: multi-cycle a+/-b over WIDTH bits, CHUNK bits per cycle through a ripple carry register,
// with unsigned/signed overflow detection and optional saturation behind valid/ready handshakes.
module arith_unit_seq #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             fs,
    input  logic             sf,
    input  logic             sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             of
);
    localparam int N  = WIDTH / CHUNK;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam int MSB = WIDTH - 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, r_q, r_d, out_q, out_d;
    logic             fs_q, fs_d, sf_q, sf_d, sat_q, sat_d, c_q, c_d, of_q, of_d;
    logic [KW-1:0]    k_q, k_d;
    logic [CHUNK:0]   sum;
    logic [WIDTH-1:0] raw, sat_val;
    logic             ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            out_q   <= '0;
            fs_q    <= 1'b0;
            sf_q    <= 1'b0;
            sat_q   <= 1'b0;
            c_q     <= 1'b0;
            of_q    <= 1'b0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            out_q   <= out_d;
            fs_q    <= fs_d;
            sf_q    <= sf_d;
            sat_q   <= sat_d;
            c_q     <= c_d;
            of_q    <= of_d;
            k_q     <= k_d;
        end
    end

    // b_q holds b' (already inverted for subtract), so the signed rule compares against it directly
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        out_d   = out_q;
        fs_d    = fs_q;
        sf_d    = sf_q;
        sat_d   = sat_q;
        c_d     = c_q;
        of_d    = of_q;
        k_d     = k_q;
        sum     = {1'b0, a_q[k_q*CHUNK +: CHUNK]} + {1'b0, b_q[k_q*CHUNK +: CHUNK]} + {{CHUNK{1'b0}}, c_q};
        raw     = r_q;
        raw[k_q*CHUNK +: CHUNK] = sum[CHUNK-1:0];
        ovf     = sf_q ? ((a_q[MSB] == b_q[MSB]) & (raw[MSB] != a_q[MSB])) : (fs_q ^ sum[CHUNK]);
        sat_val = sf_q ? {a_q[MSB], {(WIDTH-1){~a_q[MSB]}}} : {WIDTH{~fs_q}};
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = fs ? ~b : b;
                    fs_d    = fs;
                    sf_d    = sf;
                    sat_d   = sat;
                    c_d     = fs;
                    k_d     = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                r_d = raw;
                c_d = sum[CHUNK];
                k_d = k_q + 1'b1;
                if (k_q == KW'(N - 1)) begin
                    of_d    = ovf;
                    out_d   = (sat_q & ovf) ? sat_val : raw;
                    state_d = DONE;
                end
            end
            DONE: state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out       = out_q;
    assign of        = of_q;
endmodule

// File: tb/tb_arith_unit_seq.sv
// tb_arith_unit_seq: random and directed check of arith_unit_seq at CHUNK = 8, 32 and 4 against an integer reference model.
module tb_arith_unit_seq;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] a, b;
    logic        fs, sf, sat;
    logic        in_valid [3];
    logic        out_ready[3];
    logic        in_ready [3];
    logic        out_valid[3];
    logic [31:0] out      [3];
    logic        of       [3];
    int          n_of     [3] = '{4, 1, 8};
    int          vectors = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int CH = (g == 0) ? 8 : (g == 1) ? 32 : 4;
        arith_unit_seq #(.WIDTH(32), .CHUNK(CH)) dut (
            .clk(clk), .rst_n(rst_n), .in_valid(in_valid[g]), .in_ready(in_ready[g]),
            .a(a), .b(b), .fs(fs), .sf(sf), .sat(sat),
            .out_valid(out_valid[g]), .out_ready(out_ready[g]), .out(out[g]), .of(of[g])
        );
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model(input logic [31:0] x, input logic [31:0] y, input logic f, input logic s,
                                  input logic st, output logic [31:0] r, output logic o);
        longint p, q, z;
        if (s) begin
            p = longint'($signed(x));
            q = longint'($signed(y));
            z = f ? p - q : p + q;
            o = (z > 64'sd2147483647) || (z < -64'sd2147483648);
            r = 32'(z);
            if (o && st) r = x[31] ? 32'h8000_0000 : 32'h7fff_ffff;
        end else begin
            p = longint'({32'b0, x});
            q = longint'({32'b0, y});
            z = f ? p - q : p + q;
            o = f ? (y > x) : (z > 64'sd4294967295);
            r = 32'(z);
            if (o && st) r = f ? 32'h0 : 32'hffff_ffff;
        end
    endfunction

    task automatic op(input int u, input logic [31:0] ta, input logic [31:0] tb, input logic tfs,
                      input logic tsf, input logic tsat, input int hold);
        logic [31:0] er;
        logic        eo;
        int          cnt;
        model(ta, tb, tfs, tsf, tsat, er, eo);
        chk("accept_ready", in_ready[u], 1);
        a = ta; b = tb; fs = tfs; sf = tsf; sat = tsat;
        in_valid[u] = 1'b1;
        @(posedge clk); #1;
        in_valid[u] = 1'b0;
        a = $urandom; b = $urandom; fs = 1'($urandom); sf = 1'($urandom); sat = 1'($urandom);
        cnt = 0;
        while (!out_valid[u] && cnt < 40) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk("latency", cnt, n_of[u]);
        chk("out", out[u], er);
        chk("of", of[u], eo);
        repeat (hold) begin
            in_valid[u] = 1'($urandom);
            a = $urandom; b = $urandom;
            @(posedge clk); #1;
            chk("hold_out", {of[u], out[u]}, {eo, er});
            chk("hold_ready", {in_ready[u], out_valid[u]}, 2'b01);
        end
        in_valid[u] = 1'b0;
        out_ready[u] = 1'b1;
        @(posedge clk); #1;
        out_ready[u] = 1'b0;
        chk("back_to_idle", {in_ready[u], out_valid[u]}, 2'b10);
        chk("kept_out", {of[u], out[u]}, {eo, er});
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] e[5] = '{32'h0, 32'h1, 32'h7fff_ffff, 32'h8000_0000, 32'hffff_ffff};
        return ($urandom_range(0, 3) == 0) ? e[$urandom_range(0, 4)] : $urandom;
    endfunction

    logic [31:0] da[7] = '{32'hffff_ffff, 32'h5, 32'h7, 32'h7fff_ffff, 32'hffff_ffff, 32'h8000_0000, 32'h0};
    logic [31:0] db[7] = '{32'h1, 32'h7, 32'h5, 32'h1, 32'h1, 32'h1, 32'h8000_0000};
    logic        dfs[7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic        dsf[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

    initial begin
        rst_n = 1'b0;
        a = '0; b = '0; fs = 0; sf = 0; sat = 0;
        for (int u = 0; u < 3; u++) begin
            in_valid[u] = 1'b0;
            out_ready[u] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int u = 0; u < 3; u++)
            chk("reset_state", {in_ready[u], out_valid[u], of[u], out[u]}, {3'b100, 32'h0});
        for (int u = 0; u < 3; u++)
            for (int i = 0; i < 7; i++)
                for (int s = 0; s < 2; s++)
                    op(u, da[i], db[i], dfs[i], dsf[i], 1'(s), (i == 0) ? 3 : 0);
        op(0, 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 1'b0, 0);
        a = 32'hffff_ffff; b = 32'h1; fs = 0; sf = 0; sat = 0;
        in_valid[0] = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_reset", {in_ready[0], out_valid[0], of[0], out[0]}, {3'b100, 32'h0});
        @(posedge clk); #1 rst_n = 1'b1;
        op(0, 32'h0000_0003, 32'h0000_0004, 1'b1, 1'b1, 1'b0, 1);
        for (int u = 0; u < 3; u++)
            for (int i = 0; i < 30; i++)
                op(u, pick(), pick(), 1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 3));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
